// File: rtl/serial_compare_seq.sv
// Bit-serial unsigned magnitude comparator: scans captured operands MSB first,
// stopping at the first differing bit pair, and pulses done with lt/eq/gt.
module serial_compare_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  // state | meaning
  // IDLE  | waiting for start; operands and flags hold last result
  // SCAN  | comparing bit pair at r_idx, MSB first
  // DONE  | single-cycle result strobe, then back to IDLE
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam int IW = $clog2(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IW-1:0]    r_idx;

  logic w_abit;
  logic w_bbit;
  logic w_less;
  logic w_greater;

  assign w_abit    = r_a[r_idx];
  assign w_bbit    = r_b[r_idx];
  assign w_less    = ~w_abit & w_bbit;
  assign w_greater = w_abit & ~w_bbit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      lt      <= 1'b0;
      eq      <= 1'b0;
      gt      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_idx   <= IW'(WIDTH - 1);
            lt      <= 1'b0;
            eq      <= 1'b0;
            gt      <= 1'b0;
            busy    <= 1'b1;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (w_less) begin
            lt      <= 1'b1;
            done    <= 1'b1;
            r_state <= DONE;
          end else if (w_greater) begin
            gt      <= 1'b1;
            done    <= 1'b1;
            r_state <= DONE;
          end else if (r_idx == '0) begin
            eq      <= 1'b1;
            done    <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_compare_seq.sv
// Directed and random checks of serial_compare_seq at WIDTH=8.
// Latency counts rising edges with the accepting edge as 1; done is seen after edge k+1.
module tb_serial_compare_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         lt;
  logic         eq;
  logic         gt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_compare_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .lt   (lt),
    .eq   (eq),
    .gt   (gt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y);
    int  k;
    bit  found;
    k     = W;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found && (x[i] != y[i])) begin
        k     = W - i;
        found = 1'b1;
      end
    end
    return k + 1;
  endfunction

  // Entered at a negedge; leaves at the negedge of the IDLE cycle after DONE.
  task automatic run(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                     input int exp_lat, input bit hold);
    logic [2:0] exp_f;
    int         cnt;
    int         bcnt;
    exp_f = {va < vb, va == vb, va > vb};
    start = 1'b1;
    a     = va;
    b     = vb;
    @(posedge clk);
    cnt  = 1;
    bcnt = 0;
    @(negedge clk);
    check({tag, "_clr"}, {29'd0, lt, eq, gt}, 32'd0);
    while (!done && cnt < 40) begin
      if (busy) bcnt++;
      if (hold) begin
        a = W'($urandom);
        b = W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cnt++;
    end
    start = 1'b0;
    if (busy) bcnt++;
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_lat"}, cnt, exp_lat);
    check({tag, "_busycyc"}, bcnt, exp_lat);
    check({tag, "_flags"}, {29'd0, lt, eq, gt}, {29'd0, exp_f});
    @(negedge clk);
    check({tag, "_pulse"}, {30'd0, done, busy}, 32'd0);
    check({tag, "_hold"}, {29'd0, lt, eq, gt}, {29'd0, exp_f});
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    check("reset", {27'd0, busy, done, lt, eq, gt}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run("gt80", 8'h80, 8'h7F, 2, 1'b0);
    run("eq35", 8'h35, 8'h35, 9, 1'b0);
    run("lt12", 8'h12, 8'h13, 9, 1'b0);
    run("b2b_ff", 8'hFF, 8'h00, 2, 1'b0);
    run("hold", 8'h10, 8'h20, 4, 1'b1);

    start = 1'b1;
    a     = 8'h01;
    b     = 8'h02;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("midscan_busy", {30'd0, busy, done}, 32'd2);
    #2 rst = 1'b1;
    #1;
    check("async_rst", {27'd0, busy, done, lt, eq, gt}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("rst_nodone", {27'd0, busy, done, lt, eq, gt}, 32'd0);
    end
    rst = 1'b0;
    run("post_rst", 8'h21, 8'h20, 9, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = (i % 8 == 0) ? ra : W'($urandom);
      run("rnd", ra, rb, ref_lat(ra, rb), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
